// File: rtl/axi_cmd_arbiter.sv
// Round-robin arbiter that shares one AXI4-Lite master command port among NUM_REQ
// requesters, issues the start pulse, returns status and guards each transaction with a watchdog.
module axi_cmd_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int WDOG_CYCLES = 4096,
  parameter int IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*8-1:0]  req_cmd,
  input  logic [NUM_REQ*32-1:0] req_addr,
  output logic [NUM_REQ-1:0]    req_grant,
  output logic [IDX_W-1:0]      grant_idx,
  output logic [NUM_REQ-1:0]    req_done,
  output logic [7:0]            req_status,
  output logic [7:0]            m_cmd,
  output logic [31:0]           m_addr,
  output logic                  m_start,
  input  logic                  m_done,
  input  logic [7:0]            m_status,
  output logic                  busy
);

  localparam int WD_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(WDOG_CYCLES);
  localparam logic [7:0] ST_TIMEOUT = 8'h04;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_CLEAR, S_WAIT_DONE, S_RESPOND, S_RECOVER
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]    grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0]    last_idx_q, last_idx_d;
  logic [NUM_REQ-1:0]  req_done_q, req_done_d;
  logic [7:0]          status_q, status_d;
  logic [7:0]          m_cmd_q, m_cmd_d;
  logic [31:0]         m_addr_q, m_addr_d;
  logic                m_start_q, m_start_d;
  logic [WD_W-1:0]     wdog_q, wdog_d;
  logic                recover_q, recover_d;

  // Rotate requests so bit 0 is the requester right after the last grant,
  // then the lowest set bit is the round-robin winner.
  logic [2*NUM_REQ-1:0] rr_dbl;
  logic [NUM_REQ-1:0]   rr_rot;
  int unsigned          rr_sh, rr_t;
  logic                 pick_vld;
  logic [IDX_W-1:0]     pick_idx;

  always_comb begin
    rr_sh    = 32'(last_idx_q) + 32'd1;
    rr_dbl   = {req_valid, req_valid} >> rr_sh;
    rr_rot   = rr_dbl[NUM_REQ-1:0];
    pick_vld = |req_valid;
    rr_t     = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rr_rot[k]) rr_t = rr_sh + 32'(k);
    end
    if (rr_t >= 32'(NUM_REQ)) rr_t = rr_t - 32'(NUM_REQ);
    pick_idx = IDX_W'(rr_t);
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grant_idx_d = grant_idx_q;
    last_idx_d  = last_idx_q;
    req_done_d  = '0;
    status_d    = status_q;
    m_cmd_d     = m_cmd_q;
    m_addr_d    = m_addr_q;
    m_start_d   = 1'b0;
    wdog_d      = wdog_q;
    recover_d   = recover_q;

    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          grant_d     = NUM_REQ'(1) << pick_idx;
          grant_idx_d = pick_idx;
          m_cmd_d     = req_cmd[pick_idx*8 +: 8];
          m_addr_d    = req_addr[pick_idx*32 +: 32];
          m_start_d   = 1'b1;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        last_idx_d = grant_idx_q;
        wdog_d     = '0;
        state_d    = S_WAIT_CLEAR;
      end
      S_WAIT_CLEAR, S_WAIT_DONE: begin
        wdog_d = (wdog_q == WD_MAX) ? wdog_q : wdog_q + 1'b1;
        if (state_q == S_WAIT_CLEAR && !m_done) begin
          state_d = S_WAIT_DONE;
        end else if (state_q == S_WAIT_DONE && m_done) begin
          // A real completion beats a watchdog expiry in the same cycle.
          status_d   = m_status;
          req_done_d = NUM_REQ'(1) << grant_idx_q;
          state_d    = S_RESPOND;
        end else if (wdog_q == WD_MAX) begin
          status_d   = ST_TIMEOUT;
          recover_d  = 1'b1;
          req_done_d = NUM_REQ'(1) << grant_idx_q;
          state_d    = S_RESPOND;
        end
      end
      S_RESPOND: begin
        grant_d = '0;
        state_d = recover_q ? S_RECOVER : S_IDLE;
      end
      S_RECOVER: begin
        // Hold off new starts until the timed-out master finally reports.
        if (m_done) begin
          recover_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      grant_idx_q <= '0;
      last_idx_q  <= IDX_W'(NUM_REQ - 1);
      req_done_q  <= '0;
      status_q    <= 8'h00;
      m_cmd_q     <= 8'h00;
      m_addr_q    <= 32'h0;
      m_start_q   <= 1'b0;
      wdog_q      <= '0;
      recover_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      grant_idx_q <= grant_idx_d;
      last_idx_q  <= last_idx_d;
      req_done_q  <= req_done_d;
      status_q    <= status_d;
      m_cmd_q     <= m_cmd_d;
      m_addr_q    <= m_addr_d;
      m_start_q   <= m_start_d;
      wdog_q      <= wdog_d;
      recover_q   <= recover_d;
    end
  end

  assign req_grant  = grant_q;
  assign grant_idx  = grant_idx_q;
  assign req_done   = req_done_q;
  assign req_status = status_q;
  assign m_cmd      = m_cmd_q;
  assign m_addr     = m_addr_q;
  assign m_start    = m_start_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_axi_cmd_arbiter.sv
// Directed bench for axi_cmd_arbiter: table of transactions against a small AXI master
// model, plus hand sequences for watchdog recovery and mid-transaction reset.
module tb_axi_cmd_arbiter;
  localparam int NR = 4;
  localparam int WD = 16;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [NR-1:0]  req_valid;
  logic [NR*8-1:0]  req_cmd;
  logic [NR*32-1:0] req_addr;
  logic [NR-1:0]  req_grant;
  logic [IW-1:0]  grant_idx;
  logic [NR-1:0]  req_done;
  logic [7:0]     req_status;
  logic [7:0]     m_cmd;
  logic [31:0]    m_addr;
  logic           m_start;
  logic           m_done;
  logic [7:0]     m_status;
  logic           busy;

  always #5 clk = ~clk;

  axi_cmd_arbiter #(.NUM_REQ(NR), .WDOG_CYCLES(WD)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_cmd(req_cmd), .req_addr(req_addr),
    .req_grant(req_grant), .grant_idx(grant_idx),
    .req_done(req_done), .req_status(req_status),
    .m_cmd(m_cmd), .m_addr(m_addr), .m_start(m_start),
    .m_done(m_done), .m_status(m_status), .busy(busy)
  );

  // Master model: clears done cur_clr cycles after start, raises it cur_dly
  // cycles later; cur_dly==0 hangs until late_done is set.
  int        cur_clr = 1;
  int        cur_dly = 6;
  logic [7:0] cur_st = 8'h00;
  bit        late_done = 1'b0;
  int        ph = 0;
  int        cnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      m_done = 1'b0; m_status = 8'h00; ph = 0;
    end else if (m_start) begin
      ph = 1; cnt = cur_clr;
    end else begin
      case (ph)
        1: begin
          cnt = cnt - 1;
          if (cnt == 0) begin
            m_done = 1'b0; cnt = cur_dly;
            ph = (cur_dly == 0) ? 3 : 2;
          end
        end
        2: begin
          cnt = cnt - 1;
          if (cnt == 0) begin m_done = 1'b1; m_status = cur_st; ph = 0; end
        end
        3: if (late_done) begin m_done = 1'b1; m_status = 8'hEE; ph = 0; end
        default: ;
      endcase
    end
  end

  int    n_chk = 0;
  int    n_fail = 0;
  string tag = "init";

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got 0x%0h, expected 0x%0h", tag, nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_txn(input logic [3:0] mask, input logic [7:0] st, input int clr,
                         input int dly, input bit drop, input int idx, input int lat,
                         input bit recov);
    bit got;
    int lat_got, extra;
    cur_st = st; cur_clr = clr; cur_dly = dly;
    req_valid = mask;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m_start) begin got = 1'b1; break; end
    end
    chk("start_seen", 32'(got), 32'd1);
    if (!got) return;
    chk("grant", 32'(req_grant), 32'd1 << idx);
    chk("grant_idx", 32'(grant_idx), 32'(idx));
    chk("m_cmd", 32'(m_cmd), 32'h20 + 32'(idx));
    chk("m_addr", m_addr, 32'h1000 + 32'h100 * 32'(idx));
    chk("busy_issue", 32'(busy), 32'd1);
    if (drop) req_valid = '0;
    lat_got = 0; extra = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (m_start) extra++;
      if (req_done != '0) begin lat_got = i; break; end
    end
    chk("latency", 32'(lat_got), 32'(lat));
    chk("extra_start", 32'(extra), 32'd0);
    chk("req_done", 32'(req_done), 32'd1 << idx);
    chk("req_status", 32'(req_status), 32'(st));
    chk("grant_respond", 32'(req_grant), 32'd1 << idx);
    @(negedge clk);
    chk("done_pulse", 32'(req_done), 32'd0);
    chk("grant_clear", 32'(req_grant), 32'd0);
    chk("busy_after", 32'(busy), 32'(recov));
  endtask

  typedef struct {
    bit         rst_first;
    logic [3:0] mask;
    logic [7:0] st;
    int         clr;
    int         dly;
    bit         drop;
    int         idx;
    int         lat;
  } vec_t;

  vec_t vt[17];

  initial begin
    int starts;
    int busy_low;
    int noise;
    bit got;
    // latency = clr + dly + 1; 18 = watchdog tie (m_done and expiry together)
    vt[0]  = '{1'b1, 4'b0001, 8'h00, 1, 6,  1'b1, 0, 8};
    vt[1]  = '{1'b1, 4'b0011, 8'h00, 1, 6,  1'b0, 0, 8};
    vt[2]  = '{1'b0, 4'b0011, 8'h11, 1, 6,  1'b0, 1, 8};
    vt[3]  = '{1'b0, 4'b0011, 8'h22, 1, 6,  1'b0, 0, 8};
    vt[4]  = '{1'b0, 4'b0011, 8'h00, 1, 6,  1'b0, 1, 8};
    vt[5]  = '{1'b1, 4'b1111, 8'h00, 1, 6,  1'b0, 0, 8};
    vt[6]  = '{1'b0, 4'b1111, 8'h01, 1, 6,  1'b0, 1, 8};
    vt[7]  = '{1'b0, 4'b1111, 8'h02, 2, 3,  1'b0, 2, 6};
    vt[8]  = '{1'b0, 4'b1111, 8'h03, 1, 6,  1'b0, 3, 8};
    vt[9]  = '{1'b0, 4'b1111, 8'h00, 1, 6,  1'b0, 0, 8};
    vt[10] = '{1'b0, 4'b1011, 8'h00, 1, 6,  1'b0, 1, 8};
    vt[11] = '{1'b0, 4'b1011, 8'h00, 1, 6,  1'b0, 3, 8};
    vt[12] = '{1'b0, 4'b1011, 8'h00, 1, 6,  1'b0, 0, 8};
    vt[13] = '{1'b0, 4'b0010, 8'h05, 1, 6,  1'b1, 1, 8};
    vt[14] = '{1'b0, 4'b0100, 8'h00, 3, 6,  1'b0, 2, 10};
    vt[15] = '{1'b0, 4'b1000, 8'h33, 1, 16, 1'b0, 3, 18};
    vt[16] = '{1'b0, 4'b0001, 8'h00, 1, 6,  1'b0, 0, 8};

    req_valid = '0;
    for (int i = 0; i < NR; i++) begin
      req_cmd[i*8 +: 8]   = 8'h20 + 8'(i);
      req_addr[i*32 +: 32] = 32'h1000 + 32'h100 * 32'(i);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tag = "reset";
    chk("grant", 32'(req_grant), 32'd0);
    chk("grant_idx", 32'(grant_idx), 32'd0);
    chk("req_done", 32'(req_done), 32'd0);
    chk("req_status", 32'(req_status), 32'd0);
    chk("m_cmd", 32'(m_cmd), 32'd0);
    chk("m_addr", m_addr, 32'd0);
    chk("m_start", 32'(m_start), 32'd0);
    chk("busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 17; i++) begin
      tag = $sformatf("vec%0d", i);
      if (vt[i].rst_first) do_reset();
      run_txn(vt[i].mask, vt[i].st, vt[i].clr, vt[i].dly, vt[i].drop,
              vt[i].idx, vt[i].lat, 1'b0);
    end

    // Watchdog: master never answers, then the arbiter must sit in recovery.
    tag = "wdog";
    run_txn(4'b0010, 8'h04, 1, 0, 1'b0, 1, 18, 1'b1);
    starts = 0; busy_low = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m_start) starts++;
      if (!busy) busy_low++;
    end
    chk("recover_no_start", 32'(starts), 32'd0);
    chk("recover_busy", 32'(busy_low), 32'd0);
    late_done = 1'b1;
    tag = "after_recover";
    run_txn(4'b0010, 8'h5A, 1, 6, 1'b0, 1, 8, 1'b0);

    // Reset while waiting on the master.
    tag = "mid_reset";
    cur_clr = 1; cur_dly = 6; cur_st = 8'h77;
    req_valid = 4'b0001;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m_start) begin got = 1'b1; break; end
    end
    chk("start_seen", 32'(got), 32'd1);
    repeat (4) @(negedge clk);
    rst = 1'b1; req_valid = '0;
    #1;
    chk("grant", 32'(req_grant), 32'd0);
    chk("grant_idx", 32'(grant_idx), 32'd0);
    chk("m_cmd", 32'(m_cmd), 32'd0);
    chk("m_addr", m_addr, 32'd0);
    chk("busy", 32'(busy), 32'd0);
    chk("req_done", 32'(req_done), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    noise = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_done != '0 || m_start || busy) noise++;
    end
    chk("quiet_after_reset", 32'(noise), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no summary, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/axi_cmd_arbiter.md
# axi_cmd_arbiter

- Shares the single AXI4-Lite master command port (cmd/addr/start/done/status) between `NUM_REQ` command sources, e.g. the UART frame parser plus on-chip debug or scan engines.
- Arbitration is round-robin, one transaction at a time. The arbiter issues the start pulse and tracks the master's level-type done flag.
- It returns the completion status to the granted requester and guards each transaction with a watchdog.
- It sits between the requesters and the AXI master. Requesters' write/read data buffers are muxed outside the block using `grant_idx`.

## Interface

**Parameters**

- `NUM_REQ`, 2: number of requesters, 2..8.
- `WDOG_CYCLES`, 4096: maximum cycles from start to master done before forced completion.
- `IDX_W`, `max(1,$clog2(NUM_REQ))`: grant index width (derived).

**Ports**

- Clocking and reset: one clock; reset is asynchronous and active-high.
  - `clk`  in  1  clock.
  - `rst`  in  1  asynchronous active-high reset.
- Requester side:
  - `req_valid`  in  NUM_REQ  request pending per requester; held with stable cmd/addr until `req_done`.
  - `req_cmd`  in  NUM_REQ*8  command bytes, requester i at [8i+7:8i].
  - `req_addr`  in  NUM_REQ*32  addresses, requester i at [32i+31:32i].
  - `req_grant`  out  NUM_REQ  one-hot, high for the granted requester from ISSUE through RESPOND.
  - `grant_idx`  out  IDX_W  binary index of the current/last grant; drives the external data muxes.
  - `req_done`  out  NUM_REQ  one-cycle completion pulse to the granted requester.
  - `req_status`  out  8  status byte, valid while any `req_done` bit is high.
- Master side:
  - `m_cmd`  out  8  latched command to the AXI master.
  - `m_addr`  out  32  latched address to the AXI master.
  - `m_start`  out  1  one-cycle start pulse.
  - `m_done`  in  1  master done flag; clears after start, rises and holds at completion.
  - `m_status`  in  8  master status; sampled when `m_done` rises.
- `busy`  out  1  high in every state except IDLE.

## Operation

- **IDLE**
  - If any `req_valid` is set, select the first set bit searching upward from `last_idx+1`, with modulo-NUM_REQ wrap.
  - Register the one-hot grant, `grant_idx`, `m_cmd` and `m_addr` from the selected requester, then go to ISSUE.
- **ISSUE**
  - `m_start`=1 for exactly one cycle.
  - `last_idx` <= `grant_idx`; clear the watchdog; go to WAIT_CLEAR.
- **WAIT_CLEAR**
  - Wait for `m_done`=0, then go to WAIT_DONE.
  - This rejects the stale done flag held from the previous transaction.
- **WAIT_DONE**
  - On `m_done`=1: latch `m_status` into the status register and go to RESPOND.
- **Watchdog (WAIT_CLEAR and WAIT_DONE)**
  - The watchdog increments by one per cycle in both states.
  - On reaching `WDOG_CYCLES`: status register <= 8'h04 (TIMEOUT), set the recover flag, go to RESPOND.
  - The watchdog saturates at `WDOG_CYCLES`; its width is `$clog2(WDOG_CYCLES+1)`.
- **RESPOND**
  - `req_done[grant_idx]`=1 and `req_status` = status register, both for one cycle.
  - Next state: RECOVER if the recover flag is set, otherwise IDLE.
- **RECOVER**
  - Wait for `m_done`=1, then clear the recover flag and go to IDLE.
  - The master's late result is discarded, and no new start is issued while the master is busy.
- **Request hold rules**
  - `req_valid` dropping during a grant is ignored; the transaction completes and `req_done` still pulses.
  - A requester still asserting `req_valid` in the cycle after `req_done` is treated as a new request.
- **Unchanged outputs:** `m_cmd`/`m_addr` hold their values outside the IDLE to ISSUE load; `grant_idx` holds its last value in IDLE.

## Timing

- **Reset values:** state=IDLE, `req_grant`=0, `grant_idx`=0, `req_done`=0, `req_status`=8'h00, `m_cmd`=0, `m_addr`=0, `m_start`=0, `busy`=0, `last_idx`=NUM_REQ-1 (requester 0 wins the first contention), watchdog=0, recover flag=0.
- **Latency:**
  - `req_valid` sampled in IDLE at cycle T → `req_grant`/`m_cmd` valid at T+1, `m_start` high during cycle T+1.
  - `m_done` rising sampled at cycle D → `req_done` pulse during D+1.
  - RESPOND→IDLE takes one cycle, so back-to-back grants are separated by at least one IDLE cycle.
- **Outputs:** all registered except `busy`, which is decoded from state.
- **Reset mid-transaction:**
  - All outputs return to reset values asynchronously; no `req_done` is emitted.
  - The master is reset from the same `rst`.
- **Simultaneous events:**
  - Watchdog expiry and `m_done` rising in the same WAIT_DONE cycle: `m_done` wins, `m_status` is reported, no recover.
  - `m_done` already 0 on entry to WAIT_CLEAR: one cycle in WAIT_CLEAR.

## Test plan

- **Single request:** req0, cmd=8'h20, addr=0x1000; the model clears done at start+1 and raises it 6 cycles later with status 0x00 → `m_start` one cycle; `m_addr`=0x1000; `req_done[0]` one pulse; `req_status`=0x00; `busy` low the cycle after.
- **Contention after reset:** req0 and req1 asserted at the same cycle → req0 granted first, req1 granted at the next IDLE. With both held continuously, the grant sequence is 0,1,0,1.
- **Round-robin wrap, NUM_REQ=4:** all 4 held → grant order 0,1,2,3,0. Drop req2 → order skips 2 (0,1,3,0).
- **Stale done:** `m_done` held at 1 from the prior transaction, and the model clears it 3 cycles after start → no `req_done` until the next rising edge of `m_done`.
- **Watchdog, WDOG_CYCLES=16:** `m_done` stays 0 → `req_done` with `req_status`=0x04; state stays RECOVER with no `m_start` until `m_done`=1.
- **Reset and errors:**
  - Assert `rst` during WAIT_DONE → outputs immediately at reset values, no `req_done`.
  - A slave error (status 0x05) is passed through unchanged.
